// File: rtl/cla_pkg.sv
// Shared lookahead constants and the group generate/propagate helper.
// Combinational only; no latency or backpressure of its own.
package cla_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_BLOCK = 4;
  localparam int MAX_BLOCK = 32;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Generate/propagate of bits [n-1:0] taken as a single group.
  function automatic gp_t group_gp(input logic [MAX_BLOCK-1:0] g,
                                   input logic [MAX_BLOCK-1:0] p,
                                   input int                   n);
    gp_t r;
    r.g = 1'b0;
    r.p = 1'b1;
    for (int i = 0; i < MAX_BLOCK; i++) begin
      if (i < n) begin
        r.g = g[i] | (p[i] & r.g);
        r.p = r.p & p[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for the pipelined CLA adder.
// Valid/ready on both sides; in_ready is driven combinationally by the adder.
interface pipelined_cla_adder_if #(
  parameter int WIDTH = cla_pkg::DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );

endinterface

// File: rtl/cla_block.sv
// One BLOCK-bit carry-lookahead group, purely combinational (zero latency, no handshake).
// Every carry is formed from prefix generate/propagate terms rather than rippling.
module cla_block
  import cla_pkg::*;
#(
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [MAX_BLOCK-1:0] g_ext;
  logic [MAX_BLOCK-1:0] p_ext;
  logic [BLOCK:0]       c;
  gp_t                  gp;

  always_comb begin
    g_ext = '0;
    p_ext = '0;
    c     = '0;
    gp    = '0;
    g_ext[BLOCK-1:0] = a & b;
    p_ext[BLOCK-1:0] = a ^ b;
    c[0] = cin;
    for (int i = 0; i < BLOCK; i++) begin
      gp     = group_gp(g_ext, p_ext, i + 1);
      c[i+1] = gp.g | (gp.p & cin);
    end
  end

  assign sum  = p_ext[BLOCK-1:0] ^ c[BLOCK-1:0];
  assign cout = c[BLOCK];
  assign cmsb = c[BLOCK-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// WIDTH-bit add/sub, one BLOCK-bit lookahead group per stage; latency WIDTH/BLOCK cycles, 1 op/cycle.
// Backpressure: a single global advance (out_ready || !out_valid) freezes every register; in_ready = advance.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipelined_cla_adder_if.slave bus
);

  localparam int STAGES = WIDTH / BLOCK;

  if (BLOCK < 1 || BLOCK > MAX_BLOCK || WIDTH < BLOCK || (WIDTH % BLOCK) != 0) begin : g_bad_params
    $error("pipelined_cla_adder: WIDTH must be a positive multiple of BLOCK, BLOCK in 1..%0d", MAX_BLOCK);
  end

  logic              adv;
  logic              c0;
  logic [WIDTH-1:0]  b_eff;
  logic [WIDTH-1:0]  sum_out;
  logic              cmsb_last;
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  // vchain[p] is the valid of the op about to enter position p; vchain[STAGES] is out_valid.
  logic [STAGES:0]   vchain;
  logic [STAGES:0]   cchain;

  assign b_eff     = bus.in_sub ? ~bus.in_b : bus.in_b;
  assign c0        = bus.in_sub | bus.in_cin;
  assign vchain    = {v_q, bus.in_valid};
  assign cchain[0] = c0;
  assign adv       = bus.out_ready | ~vchain[STAGES];
  assign v_d       = adv ? vchain[STAGES-1:0] : v_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
    end else begin
      v_q <= v_d;
    end
  end

  // Data registers only load for valid ops, so bubbles leave the last result on the outputs.
  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    logic [BLOCK-1:0] a_st;
    logic [BLOCK-1:0] b_st;
    logic [BLOCK-1:0] sum_st;
    logic             cout_st;
    logic             cmsb_st;
    logic             c_q;
    logic [BLOCK-1:0] s_q [STAGES-k];

    if (k == 0) begin : g_direct
      assign a_st = bus.in_a[BLOCK-1:0];
      assign b_st = b_eff[BLOCK-1:0];
    end else begin : g_skew
      logic [BLOCK-1:0] a_q [k];
      logic [BLOCK-1:0] b_q [k];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int d = 0; d < k; d++) begin
            a_q[d] <= '0;
            b_q[d] <= '0;
          end
        end else if (adv) begin
          if (vchain[0]) begin
            a_q[0] <= bus.in_a[k*BLOCK +: BLOCK];
            b_q[0] <= b_eff[k*BLOCK +: BLOCK];
          end
          for (int d = 1; d < k; d++) begin
            if (vchain[d]) begin
              a_q[d] <= a_q[d-1];
              b_q[d] <= b_q[d-1];
            end
          end
        end
      end

      assign a_st = a_q[k-1];
      assign b_st = b_q[k-1];
    end

    cla_block #(
      .BLOCK (BLOCK)
    ) u_cla (
      .a    (a_st),
      .b    (b_st),
      .cin  (cchain[k]),
      .sum  (sum_st),
      .cout (cout_st),
      .cmsb (cmsb_st)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        c_q <= 1'b0;
        for (int j = 0; j < STAGES - k; j++) begin
          s_q[j] <= '0;
        end
      end else if (adv) begin
        if (vchain[k]) begin
          c_q    <= cout_st;
          s_q[0] <= sum_st;
        end
        for (int j = 1; j < STAGES - k; j++) begin
          if (vchain[k+j]) begin
            s_q[j] <= s_q[j-1];
          end
        end
      end
    end

    assign cchain[k+1]                = c_q;
    assign sum_out[k*BLOCK +: BLOCK] = s_q[STAGES-1-k];

    if (k == STAGES - 1) begin : g_msb
      logic m_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          m_q <= 1'b0;
        end else if (adv && vchain[k]) begin
          m_q <= cmsb_st;
        end
      end

      assign cmsb_last = m_q;
    end else begin : g_mid
      logic unused_cmsb;
      assign unused_cmsb = cmsb_st;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = vchain[STAGES];
  assign bus.out_sum   = sum_out;
  assign bus.out_cout  = cchain[STAGES];
  assign bus.out_ovf   = cmsb_last ^ cchain[STAGES];

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed and randomised checks of the pipelined CLA adder at 16/4 and 4/4 geometry.
// Covers latency, arithmetic/flags, stall hold, in-order drain and mid-stream reset.
module tb_pipelined_cla_adder;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int got    = 0;

  beat_t       pending[$];
  logic [17:0] exp_q[$];

  pipelined_cla_adder_if #(.WIDTH(16)) bus16 ();
  pipelined_cla_adder_if #(.WIDTH(4))  bus4 ();

  pipelined_cla_adder #(.WIDTH(16), .BLOCK(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  pipelined_cla_adder #(.WIDTH(4), .BLOCK(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {ovf, cout, sum} from plain integer arithmetic on the effective operands.
  function automatic logic [17:0] model16(input beat_t t);
    logic [15:0] bb;
    logic [16:0] full;
    logic        c0;
    logic        ovf;
    bb   = t.sub ? ~t.b : t.b;
    c0   = t.sub ? 1'b1 : t.cin;
    full = {1'b0, t.a} + {1'b0, bb} + {16'd0, c0};
    ovf  = (t.a[15] == bb[15]) && (full[15] != t.a[15]);
    return {ovf, full[16], full[15:0]};
  endfunction

  // Called at posedge+1; offers the head of pending, retires a result if handshaken.
  task automatic step(input logic ordy);
    logic [17:0] e;
    bus16.out_ready = ordy;
    if (pending.size() > 0) begin
      bus16.in_valid = 1'b1;
      bus16.in_a     = pending[0].a;
      bus16.in_b     = pending[0].b;
      bus16.in_cin   = pending[0].cin;
      bus16.in_sub   = pending[0].sub;
    end else begin
      bus16.in_valid = 1'b0;
    end
    #1;
    if (bus16.out_valid && bus16.out_ready) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stream result", 32'({bus16.out_ovf, bus16.out_cout, bus16.out_sum}), 32'(e));
        got++;
      end else begin
        check("spurious out_valid", 32'(bus16.out_valid), 32'(0));
      end
    end
    if (bus16.in_valid && bus16.in_ready) begin
      exp_q.push_back(model16(pending[0]));
      void'(pending.pop_front());
    end
    @(posedge clk);
    #1;
    bus16.in_valid = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub,
                          input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    bus16.out_ready = 1'b1;
    bus16.in_a      = a;
    bus16.in_b      = b;
    bus16.in_cin    = cin;
    bus16.in_sub    = sub;
    bus16.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus16.in_valid = 1'b0;
    lat = 1;
    while (!bus16.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, lat, 4);
    check({tag, " sum"}, 32'(bus16.out_sum), 32'(es));
    check({tag, " cout"}, 32'(bus16.out_cout), 32'(ec));
    check({tag, " ovf"}, 32'(bus16.out_ovf), 32'(eo));
    @(posedge clk);
    #1;
    check({tag, " drained"}, 32'(bus16.out_valid), 32'(0));
    check({tag, " held sum"}, 32'(bus16.out_sum), 32'(es));
  endtask

  task automatic directed4(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic cin, input logic sub,
                           input logic [3:0] es, input logic ec, input logic eo);
    int lat;
    bus4.out_ready = 1'b1;
    bus4.in_a      = a;
    bus4.in_b      = b;
    bus4.in_cin    = cin;
    bus4.in_sub    = sub;
    bus4.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus4.in_valid = 1'b0;
    lat = 1;
    while (!bus4.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, lat, 1);
    check({tag, " sum"}, 32'(bus4.out_sum), 32'(es));
    check({tag, " cout"}, 32'(bus4.out_cout), 32'(ec));
    check({tag, " ovf"}, 32'(bus4.out_ovf), 32'(eo));
    @(posedge clk);
    #1;
  endtask

  initial begin
    beat_t       bt;
    logic [31:0] r;
    logic [31:0] r2;
    logic [15:0] hold;
    int          it;
    int          got0;

    bus16.in_valid = 1'b0; bus16.in_a = '0; bus16.in_b = '0;
    bus16.in_cin = 1'b0; bus16.in_sub = 1'b0; bus16.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.in_a = '0; bus4.in_b = '0;
    bus4.in_cin = 1'b0; bus4.in_sub = 1'b0; bus4.out_ready = 1'b1;

    #1 rst_n = 1'b0;
    #1;
    check("reset out_valid", 32'(bus16.out_valid), 32'(0));
    check("reset out_sum", 32'(bus16.out_sum), 32'(0));
    check("reset out_cout", 32'(bus16.out_cout), 32'(0));
    check("reset out_ovf", 32'(bus16.out_ovf), 32'(0));
    check("reset in_ready", 32'(bus16.in_ready), 32'(1));
    check("reset w4 out_valid", 32'(bus4.out_valid), 32'(0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("post-release in_ready", 32'(bus16.in_ready), 32'(1));

    directed("ffff+1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("7fff+1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("5-7", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed("8000-1", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    directed("cin add", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    directed("7-7 cin ignored", 16'h0007, 16'h0007, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
    directed("group carry", 16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

    directed4("w4 7+f+1", 4'b0111, 4'b1111, 1'b1, 1'b0, 4'b0111, 1'b1, 1'b0);
    directed4("w4 7+1", 4'b0111, 4'b0001, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1);

    // Back-to-back random stream: one result per cycle once the pipe is primed.
    for (int i = 0; i < 1000; i++) begin
      r  = $urandom();
      r2 = $urandom();
      bt.a   = r[15:0];
      bt.b   = r[31:16];
      bt.cin = r2[0];
      bt.sub = r2[1];
      pending.push_back(bt);
    end
    got = 0;
    it  = 0;
    while (got < 1000 && it < 1500) begin
      step(1'b1);
      it++;
    end
    check("random count", got, 1000);
    check("random cycles", it, 1004);

    // Stall: fill the pipe with out_ready low, hold, then drain.
    for (int k = 0; k < 6; k++) begin
      bt.a   = 16'(16'h1111 * (k + 1));
      bt.b   = 16'h0101;
      bt.cin = 1'b0;
      bt.sub = (k == 2);
      pending.push_back(bt);
    end
    got0 = got;
    for (int i = 0; i < 4; i++) step(1'b0);
    check("stall out_valid", 32'(bus16.out_valid), 32'(1));
    check("stall in_ready", 32'(bus16.in_ready), 32'(0));
    check("stall head sum", 32'(bus16.out_sum), 32'(16'h1212));
    hold = bus16.out_sum;
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      check("stall hold in_ready", 32'(bus16.in_ready), 32'(0));
      check("stall hold sum", 32'(bus16.out_sum), 32'(hold));
    end
    it = 0;
    while ((got - got0) < 6 && it < 30) begin
      step(1'b1);
      it++;
    end
    check("stall drain count", got - got0, 6);
    check("stall queue empty", exp_q.size(), 0);

    // Reset with three ops in flight.
    for (int k = 0; k < 3; k++) begin
      bt.a   = 16'hAAAA;
      bt.b   = 16'(16'h5555 + k);
      bt.cin = 1'b1;
      bt.sub = 1'b0;
      pending.push_back(bt);
    end
    for (int i = 0; i < 3; i++) step(1'b1);
    check("inflight none out yet", 32'(bus16.out_valid), 32'(0));
    check("inflight held sum", 32'(bus16.out_sum), 32'(16'h6767));
    bus16.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midreset out_valid", 32'(bus16.out_valid), 32'(0));
    check("midreset out_sum", 32'(bus16.out_sum), 32'(0));
    check("midreset out_cout", 32'(bus16.out_cout), 32'(0));
    check("midreset out_ovf", 32'(bus16.out_ovf), 32'(0));
    check("midreset in_ready", 32'(bus16.in_ready), 32'(1));
    exp_q.delete();
    pending.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1);
    directed("after reset", 16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
